// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared constants and types for the ROB allocation controller.
package rob_alloc_ctrl_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int CNT_W     = IDX_W + 1;

  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rob_ctrl_state_e;

  // Number of granted lanes (0..2).
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rob_alloc_ctrl_ptr.sv
// Modulo-2^W pointer with synchronous clear and increment by 0, 1 or 2.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear wins over increment; wrap is the natural W-bit overflow.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else begin
      ptr_d = ptr_q + W'(inc_i);
    end
  end

  // Pointer register with synchronous reset to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: hands out in-order ROB indices to two dispatch
// lanes, tracks head/tail/occupancy, and sequences a two-entry-per-cycle
// clear sweep after reset and flush.
//
// Handshake: disp_req_i is a per-lane request; disp_grant_o is the same-cycle
// accept. A lane's slot is consumed exactly in a cycle where its grant is 1,
// and lane 2 can only be granted together with lane 1 (program order).
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      disp_req_i,
  output logic [1:0]      disp_grant_o,
  output rob_idx_t        rob_index_1_o,
  output rob_idx_t        rob_index_2_o,
  input  logic [1:0]      num_retired_i,
  input  logic            flush_i,
  output rob_idx_t        head_o,
  output rob_cnt_t        count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            busy_o,
  output logic            clr_valid_o,
  output rob_idx_t        clr_idx_1_o,
  output rob_idx_t        clr_idx_2_o,
  output rob_ctrl_state_e state_dbg_o
);

  rob_ctrl_state_e state_q, state_d;
  rob_cnt_t        count_q, count_d;

  rob_idx_t   head, tail, sweep;
  rob_cnt_t   free_slots;
  logic       run_ok;
  logic [1:0] grant;
  logic [1:0] n_grant;
  logic [1:0] r_sat;
  logic [1:0] r_eff;
  logic       ptr_clr;
  logic       sweep_clr;
  logic [1:0] sweep_inc;

  // Grant, retire clamp and capacity decode; capacity uses registered count only.
  always_comb begin
    free_slots = rob_cnt_t'(ROB_DEPTH) - count_q;
    run_ok     = (state_q == RUN) && !flush_i;
    grant      = 2'b00;
    grant[0]   = run_ok && disp_req_i[0] && (free_slots >= rob_cnt_t'(1));
    grant[1]   = run_ok && disp_req_i[0] && disp_req_i[1] &&
                 (free_slots >= rob_cnt_t'(2));
    n_grant    = popcount2(grant);
    r_sat      = (num_retired_i == 2'd3) ? 2'd2 : num_retired_i;
    r_eff      = 2'd0;
    if (run_ok) begin
      r_eff = (rob_cnt_t'(r_sat) > count_q) ? count_q[1:0] : r_sat;
    end
  end

  // Next state and occupancy; flush and CLEAR force the ring empty.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ptr_clr   = 1'b0;
    sweep_clr = 1'b0;
    sweep_inc = 2'd0;
    case (state_q)
      CLEAR: begin
        ptr_clr   = 1'b1;
        count_d   = '0;
        sweep_inc = 2'd2;
        if (sweep == rob_idx_t'(ROB_DEPTH - 2)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        sweep_clr = 1'b1;
        if (flush_i) begin
          state_d = CLEAR;
          ptr_clr = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + rob_cnt_t'(n_grant) - rob_cnt_t'(r_eff);
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_clr = 1'b1;
        count_d = '0;
      end
    endcase
  end

  // State and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Flag illegal dispatch/retire inputs seen while allocating.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RUN) && !flush_i) begin
      assert (num_retired_i != 2'd3)
        else $warning("rob_alloc_ctrl: num_retired_i == 3 treated as 2");
      assert (rob_cnt_t'(r_sat) <= count_q)
        else $warning("rob_alloc_ctrl: retire exceeds occupancy, clamped");
      assert (disp_req_i != 2'b10)
        else $warning("rob_alloc_ctrl: lane 2 request without lane 1");
    end
  end

  rob_ptr #(.W(IDX_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ptr_clr),
    .inc_i (r_eff),
    .ptr_o (head)
  );

  rob_ptr #(.W(IDX_W)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ptr_clr),
    .inc_i (n_grant),
    .ptr_o (tail)
  );

  rob_ptr #(.W(IDX_W)) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .clr_i (sweep_clr),
    .inc_i (sweep_inc),
    .ptr_o (sweep)
  );

  assign disp_grant_o  = grant;
  assign rob_index_1_o = tail;
  assign rob_index_2_o = tail + rob_idx_t'(1);
  assign head_o        = head;
  assign count_o       = count_q;
  assign full_o        = (count_q == rob_cnt_t'(ROB_DEPTH));
  assign empty_o       = (count_q == '0);
  assign busy_o        = (state_q == CLEAR);
  assign clr_valid_o   = (state_q == CLEAR);
  assign clr_idx_1_o   = sweep;
  assign clr_idx_2_o   = sweep + rob_idx_t'(1);
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl with a per-cycle expected-output queue.
module tb_rob_alloc_ctrl;
  import rob_alloc_ctrl_pkg::*;

  localparam int W = 24;

  logic            clk;
  logic            rst;
  logic [1:0]      disp_req_i;
  logic [1:0]      disp_grant_o;
  rob_idx_t        rob_index_1_o;
  rob_idx_t        rob_index_2_o;
  logic [1:0]      num_retired_i;
  logic            flush_i;
  rob_idx_t        head_o;
  rob_cnt_t        count_o;
  logic            full_o;
  logic            empty_o;
  logic            busy_o;
  logic            clr_valid_o;
  rob_idx_t        clr_idx_1_o;
  rob_idx_t        clr_idx_2_o;
  rob_ctrl_state_e state_dbg_o;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  rob_alloc_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .disp_req_i    (disp_req_i),
    .disp_grant_o  (disp_grant_o),
    .rob_index_1_o (rob_index_1_o),
    .rob_index_2_o (rob_index_2_o),
    .num_retired_i (num_retired_i),
    .flush_i       (flush_i),
    .head_o        (head_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .busy_o        (busy_o),
    .clr_valid_o   (clr_valid_o),
    .clr_idx_1_o   (clr_idx_1_o),
    .clr_idx_2_o   (clr_idx_2_o),
    .state_dbg_o   (state_dbg_o)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  // Expected word: {grant[1:0], idx1[4:0], head[4:0], count[5:0], busy, clr1[4:0]}
  task automatic step(input logic [1:0] req, input logic [1:0] ret,
                      input logic fl, input logic [1:0] e_grant,
                      input int e_idx1, input int e_head, input int e_count,
                      input logic e_busy, input int e_clr1);
    disp_req_i    = req;
    num_retired_i = ret;
    flush_i       = fl;
    exp_q.push_back({e_grant, 5'(e_idx1), 5'(e_head), 6'(e_count), e_busy,
                     5'(e_clr1)});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle that has a queued expectation, compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      int e_idx1, e_count, e_clr1;
      e       = exp_q.pop_front();
      e_idx1  = int'(e[21:17]);
      e_count = int'(e[11:6]);
      e_clr1  = int'(e[4:0]);
      check("grant",     int'(disp_grant_o),  int'(e[23:22]));
      check("idx1",      int'(rob_index_1_o), e_idx1);
      check("idx2",      int'(rob_index_2_o), (e_idx1 + 1) % 32);
      check("head",      int'(head_o),        int'(e[16:12]));
      check("count",     int'(count_o),       e_count);
      check("full",      int'(full_o),        (e_count == 32) ? 1 : 0);
      check("empty",     int'(empty_o),       (e_count == 0) ? 1 : 0);
      check("busy",      int'(busy_o),        int'(e[5]));
      check("clr_valid", int'(clr_valid_o),   int'(e[5]));
      check("clr1",      int'(clr_idx_1_o),   e_clr1);
      check("clr2",      int'(clr_idx_2_o),   (e_clr1 + 1) % 32);
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    disp_req_i = 2'b00;
    num_retired_i = 2'd0;
    flush_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset sweep: 16 cycles, pairs (0,1)..(30,31).
    for (int k = 0; k < 16; k++) step(2'b00, 2'd0, 1'b0, 2'b00, 0, 0, 0, 1'b1, 2 * k);

    // Fill with double grants up to count 30.
    for (int k = 0; k < 15; k++) step(2'b11, 2'd0, 1'b0, 2'b11, 2 * k, 0, 2 * k, 1'b0, 0);
    // Single lane to 31, then partial grant at tail 31.
    step(2'b01, 2'd0, 1'b0, 2'b01, 30, 0, 30, 1'b0, 0);
    step(2'b11, 2'd0, 1'b0, 2'b01, 31, 0, 31, 1'b0, 0);
    // Full: no grant.
    step(2'b11, 2'd0, 1'b0, 2'b00, 0, 0, 32, 1'b0, 0);
    // Retire 2 while full: capacity is not freed this cycle.
    step(2'b11, 2'd2, 1'b0, 2'b00, 0, 0, 32, 1'b0, 0);
    // Grant with wrapped indices 0,1 and head 2.
    step(2'b11, 2'd0, 1'b0, 2'b11, 0, 2, 30, 1'b0, 0);
    // Drain by 2 per cycle; head wraps past 31.
    for (int k = 0; k < 15; k++) step(2'b00, 2'd2, 1'b0, 2'b00, 2, (2 + 2 * k) % 32, 32 - 2 * k, 1'b0, 0);
    step(2'b00, 2'd1, 1'b0, 2'b00, 2, 0, 2, 1'b0, 0);
    // Build up to count 10 (head 1, tail 11).
    for (int k = 0; k < 4; k++) step(2'b11, 2'd0, 1'b0, 2'b11, 2 + 2 * k, 1, 1 + 2 * k, 1'b0, 0);
    step(2'b01, 2'd0, 1'b0, 2'b01, 10, 1, 9, 1'b0, 0);
    // Flush with dispatch and retire: flush wins.
    step(2'b11, 2'd1, 1'b1, 2'b00, 11, 1, 10, 1'b0, 0);
    // Sweep restarts; requests and repeated flush during it are ignored.
    for (int k = 0; k < 16; k++)
      step((k < 4) ? 2'b11 : 2'b00, 2'd1, (k == 3 || k == 9) ? 1'b1 : 1'b0,
           2'b00, 0, 0, 0, 1'b1, 2 * k);
    // Reach count 5 (tail 5).
    step(2'b11, 2'd0, 1'b0, 2'b11, 0, 0, 0, 1'b0, 0);
    step(2'b11, 2'd0, 1'b0, 2'b11, 2, 0, 2, 1'b0, 0);
    step(2'b01, 2'd0, 1'b0, 2'b01, 4, 0, 4, 1'b0, 0);
    // Illegal inputs: retire 3 acts as 2, lone lane-2 request is not granted.
    step(2'b10, 2'd3, 1'b0, 2'b00, 5, 0, 5, 1'b0, 0);
    step(2'b00, 2'd0, 1'b0, 2'b00, 5, 2, 3, 1'b0, 0);

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_alloc_ctrl.md
# rob_alloc_ctrl

Allocation and sequencing controller for the 32-entry reorder buffer. Hands ROB indices to the two dispatch lanes in program order, tracks head/tail/occupancy from the retire count reported by the ROB, and back-pressures dispatch when the buffer is full. It also sequences a two-entries-per-cycle clear sweep of the ROB after reset and on pipeline flush. It sits between the dispatch/rename stage and `rob`.

## Interface
Parameters:
- ROB_DEPTH, 32, number of ROB entries; power of two, even.
- IDX_W, $clog2(ROB_DEPTH) = 5, ROB index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous and active-high.
- disp_req_i  in  2  bit0 = lane 1 wants a slot, bit1 = lane 2 wants a slot.
- disp_grant_o  out  2  per-lane grant; combinational in the request cycle.
- rob_index_1_o  out  IDX_W  index assigned to lane 1 (equals tail).
- rob_index_2_o  out  IDX_W  index assigned to lane 2.
- num_retired_i  in  2  entries retired by the ROB this cycle (0..2).
- flush_i  in  1  discard all in-flight entries (mispredict/exception).
- head_o  out  IDX_W  oldest entry (retire pointer).
- count_o  out  IDX_W+1  occupancy, 0..ROB_DEPTH.
- full_o / empty_o  out  1 each  count == ROB_DEPTH / count == 0.
- busy_o  out  1  high while state is CLEAR.
- clr_valid_o  out  1  high in CLEAR; ROB resets the two entries named below.
- clr_idx_1_o / clr_idx_2_o  out  IDX_W each  entries being cleared (sweep, sweep+1).

## Operation
- States: CLEAR and RUN.
  - CLEAR: sweep pointer steps by 2 from 0. After the cycle that clears ROB_DEPTH-2 and ROB_DEPTH-1, go to RUN.
  - RUN: normal allocate/retire.
  - flush_i in RUN: go to CLEAR, sweep=0, head=tail=count=0.
  - flush_i in CLEAR: ignored; the sweep continues.
- Grant rules (RUN only, and only when !flush_i). `free` = ROB_DEPTH − count, taken from registered count.
  - grant[0] = req[0] && free ≥ 1.
  - grant[1] = req[1] && req[0] && free ≥ 2.
  - req[1] without req[0] is illegal: no grant, assertion fires.
  - Partial grant is allowed: lane 1 granted, lane 2 stalled.
- Retire does not free capacity in the same cycle; capacity comes from registered count only.
- Index assignment:
  - rob_index_1_o = tail.
  - rob_index_2_o = tail+1 mod ROB_DEPTH.
  - Indices are valid only with the matching grant.
- Update at posedge in RUN, with g = popcount(grant) and r = num_retired_i:
  - tail += g, head += r, both mod ROB_DEPTH (natural IDX_W wrap).
  - count += g − r.
- Retire checks:
  - r == 3 is illegal: treated as 2, assertion fires.
  - r > count is clamped to count, assertion fires.
- In CLEAR: grants are 0, num_retired_i is ignored, head/tail/count are held at 0.

## Timing
- rst sampled high at posedge sets state=CLEAR, sweep=0, head=tail=count=0.
- Outputs after reset: disp_grant_o=0, rob_index_1_o=0, rob_index_2_o=1, head_o=0, count_o=0, full_o=0, empty_o=1, busy_o=1, clr_valid_o=1, clr_idx_1_o=0, clr_idx_2_o=1.
- Reset mid-sweep or mid-run restarts the sweep from 0.
- CLEAR lasts exactly ROB_DEPTH/2 = 16 cycles. The first RUN cycle may grant.
- Grant latency: 0 cycles (combinational from req). Pointer and count effects are visible the next cycle.
- head_o, count_o, full_o, empty_o, busy_o and clr_* are registered or pure decode of registered state. They never depend combinationally on inputs.
- Wrap: tail = 31 with 2 grants gives rob_index_2_o = 0 and next tail = 1. Same rule for head.
- Simultaneous dispatch and retire in one cycle are both applied.
- Simultaneous flush and dispatch/retire: flush wins; no grants, and the retire is dropped.

## Structure
- respackage gains:
  - constant ROB_DEPTH.
  - typedef rob_idx_t (logic [IDX_W-1:0]).
  - enum rob_ctrl_state_e {CLEAR, RUN}.
- One sub-module, rob_ptr:
  - modulo-ROB_DEPTH pointer with synchronous clear and increment-by-0/1/2.
  - instantiated for head, tail and the sweep pointer.
- Grant/capacity logic and count arithmetic stay in rob_alloc_ctrl. Count is kept explicitly, not derived from head/tail, so full and empty are unambiguous.

## Test plan
- Reset pulse, no requests → busy_o=1 for 16 cycles; clr_idx pairs run (0,1)…(30,31); then busy_o=0, empty_o=1, count_o=0.
- In RUN, disp_req_i=2'b11 for 16 cycles, no retire → each cycle both lanes granted with indices (0,1)…(30,31). After that full_o=1, count_o=32, and further requests get grant 0.
- From full, num_retired_i=2 with req=2'b11 in the same cycle → grant 0 that cycle, count_o=30. Next cycle grant=2'b11 with indices 0,1 (wrap), and head_o=2.
- With count=31, req=2'b11 → grant=2'b01, index 31; count_o=32; next tail=0.
- With count=10, flush_i=1 together with req=2'b11 and num_retired_i=1 → grant 0. Next cycle busy_o=1, head_o=0, count_o=0, clr_idx=(0,1). flush_i asserted again during the sweep does not restart it.
- Illegal inputs: num_retired_i=3 with count=5, and req=2'b10 → count_o=3, lane 2 not granted, both assertions fire.
